// File: rtl/mips_multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath.
// Moore machine: opcode decode, per-state datapath enables and mux selects.
module mips_multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    output logic       pcEn,
    output logic       iOrD,
    output logic       memWrite,
    output logic       irWrite,
    output logic       regDst,
    output logic       memToReg,
    output logic       regWrite,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] aluOp,
    output logic [1:0] pcSrc,
    output logic       instrDone,
    output logic       illegalOp,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_BNEEX   = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11,
        S_JEX     = 4'd12
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t state_q;
    state_t state_d;
    logic   op_legal;
    logic   pc_write;
    logic   branch;
    logic   branch_ne;

    assign op_legal = (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
                      (op == OP_BEQ) || (op == OP_BNE) || (op == OP_ADDI) ||
                      (op == OP_J);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_BNE:       state_d = S_BNEEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
                    default:      state_d = S_FETCH;
                endcase
            end
            // op is held by the IR, which only loads in FETCH
            S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_d = S_MEMWB;
            S_RTYPEEX: state_d = S_RTYPEWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pc_write  = 1'b0;
        branch    = 1'b0;
        branch_ne = 1'b0;
        iOrD      = 1'b0;
        memWrite  = 1'b0;
        irWrite   = 1'b0;
        regDst    = 1'b0;
        memToReg  = 1'b0;
        regWrite  = 1'b0;
        aluSrcA   = 1'b0;
        aluSrcB   = 2'b00;
        aluOp     = 2'b00;
        pcSrc     = 2'b00;
        instrDone = 1'b0;
        illegalOp = 1'b0;
        case (state_q)
            S_FETCH: begin
                irWrite  = 1'b1;
                pc_write = 1'b1;
                aluSrcB  = 2'b01;
            end
            S_DECODE: begin
                aluSrcB = 2'b11;
                if (!op_legal) begin
                    illegalOp = 1'b1;
                    instrDone = 1'b1;
                end
            end
            S_MEMADR, S_ADDIEX: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
            end
            S_MEMRD: iOrD = 1'b1;
            S_MEMWB: begin
                regWrite  = 1'b1;
                memToReg  = 1'b1;
                instrDone = 1'b1;
            end
            S_MEMWR: begin
                iOrD      = 1'b1;
                memWrite  = 1'b1;
                instrDone = 1'b1;
            end
            S_RTYPEEX: begin
                aluSrcA = 1'b1;
                aluOp   = 2'b10;
            end
            S_RTYPEWB: begin
                regWrite  = 1'b1;
                regDst    = 1'b1;
                instrDone = 1'b1;
            end
            S_BEQEX, S_BNEEX: begin
                aluSrcA   = 1'b1;
                aluOp     = 2'b01;
                pcSrc     = 2'b01;
                branch    = (state_q == S_BEQEX);
                branch_ne = (state_q == S_BNEEX);
                instrDone = 1'b1;
            end
            S_ADDIWB: begin
                regWrite  = 1'b1;
                instrDone = 1'b1;
            end
            S_JEX: begin
                pcSrc     = 2'b10;
                pc_write  = 1'b1;
                instrDone = 1'b1;
            end
            default: ;
        endcase
    end

    assign pcEn  = pc_write | (branch & zero) | (branch_ne & ~zero);
    assign state = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: directed plan items, then random
// opcodes and zero flags checked against an instruction-level model.
module tb_mips_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic       zero;
    logic       pcEn, iOrD, memWrite, irWrite, regDst, memToReg, regWrite;
    logic       aluSrcA, instrDone, illegalOp;
    logic [1:0] aluSrcB, aluOp, pcSrc;
    logic [3:0] state;
    logic [14:0] ctrl;

    int vectors = 0;
    int errors  = 0;

    logic [5:0] legal_ops [7] = '{6'b100011, 6'b101011, 6'b000000,
                                  6'b000100, 6'b000101, 6'b001000,
                                  6'b000010};

    mips_multicycle_control dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero),
        .pcEn(pcEn), .iOrD(iOrD), .memWrite(memWrite), .irWrite(irWrite),
        .regDst(regDst), .memToReg(memToReg), .regWrite(regWrite),
        .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
        .pcSrc(pcSrc), .instrDone(instrDone), .illegalOp(illegalOp),
        .state(state)
    );

    always #5 clk = ~clk;

    assign ctrl = {iOrD, memWrite, irWrite, regDst, memToReg, regWrite,
                   aluSrcA, aluSrcB, aluOp, pcSrc, instrDone, illegalOp};

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic is_legal(input logic [5:0] o);
        for (int k = 0; k < 7; k++)
            if (legal_ops[k] == o) return 1'b1;
        return 1'b0;
    endfunction

    // Cycles per instruction, FETCH inclusive
    function automatic int path_len(input logic [5:0] o);
        case (o)
            6'b100011:                       return 5;
            6'b101011, 6'b000000, 6'b001000: return 4;
            6'b000100, 6'b000101, 6'b000010: return 3;
            default:                         return 2;
        endcase
    endfunction

    function automatic int path_state(input logic [5:0] o, input int i);
        if (i < 2) return i;
        case (o)
            6'b100011: return (i == 2) ? 2 : (i == 3) ? 3 : 4;
            6'b101011: return (i == 2) ? 2 : 5;
            6'b000000: return (i == 2) ? 6 : 7;
            6'b001000: return (i == 2) ? 10 : 11;
            6'b000100: return 8;
            6'b000101: return 9;
            default:   return 12;
        endcase
    endfunction

    function automatic logic [14:0] exp_ctrl(input int st, input logic ill);
        logic       i_or_d, mem_wr, ir_wr, reg_dst, m2r, reg_wr, src_a;
        logic [1:0] src_b, alu_op, pc_src;
        logic       done, bad;
        i_or_d = 0; mem_wr = 0; ir_wr = 0; reg_dst = 0; m2r = 0;
        reg_wr = 0; src_a = 0; src_b = 0; alu_op = 0; pc_src = 0;
        done = 0; bad = 0;
        case (st)
            0: begin ir_wr = 1; src_b = 2'b01; end
            1: begin src_b = 2'b11; done = ill; bad = ill; end
            2, 10: begin src_a = 1; src_b = 2'b10; end
            3: i_or_d = 1;
            4: begin reg_wr = 1; m2r = 1; done = 1; end
            5: begin i_or_d = 1; mem_wr = 1; done = 1; end
            6: begin src_a = 1; alu_op = 2'b10; end
            7: begin reg_wr = 1; reg_dst = 1; done = 1; end
            8, 9: begin src_a = 1; alu_op = 2'b01; pc_src = 2'b01; done = 1; end
            11: begin reg_wr = 1; done = 1; end
            12: begin pc_src = 2'b10; done = 1; end
            default: ;
        endcase
        return {i_or_d, mem_wr, ir_wr, reg_dst, m2r, reg_wr, src_a,
                src_b, alu_op, pc_src, done, bad};
    endfunction

    function automatic logic exp_pc(input int st, input logic z);
        return (st == 0) || (st == 12) || (st == 8 && z) || (st == 9 && !z);
    endfunction

    // Entered on a negedge with the FSM in FETCH; leaves it in the next FETCH.
    // zmode: 0/1 force zero, 2 random every cycle
    task automatic run_instr(input logic [5:0] o, input int zmode);
        int   n = path_len(o);
        int   st;
        logic z;
        op = o;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            z = (zmode == 2) ? 1'($urandom) : zmode[0];
            zero = z;
            #1;
            st = path_state(o, i);
            check("state", 32'(state), 32'(st));
            check("ctrl", 32'(ctrl), 32'(exp_ctrl(st, !is_legal(o))));
            check("pcEn", 32'(pcEn), 32'(exp_pc(st, z)));
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        op    = 6'b000000;
        zero  = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_ctrl", 32'(ctrl), 32'(exp_ctrl(0, 1'b0)));
        check("rst_pcEn", 32'(pcEn), 32'd1);
        @(negedge clk);
        reset = 1'b0;

        run_instr(6'b100011, 2);
        run_instr(6'b000000, 2);
        run_instr(6'b000100, 1);
        run_instr(6'b000100, 0);
        run_instr(6'b000101, 0);
        run_instr(6'b000010, 2);
        run_instr(6'b001000, 2);
        run_instr(6'b111111, 2);

        // Reset in the middle of a store, while memWrite is high
        op = 6'b101011;
        repeat (3) @(negedge clk);
        #1;
        check("mid_sw_state", 32'(state), 32'd5);
        check("mid_sw_memWrite", 32'(memWrite), 32'd1);
        reset = 1'b1;
        #1;
        check("async_rst_state", 32'(state), 32'd0);
        check("async_rst_memWrite", 32'(memWrite), 32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_state", 32'(state), 32'd0);
        check("post_rst_irWrite", 32'(irWrite), 32'd1);
        check("post_rst_pcEn", 32'(pcEn), 32'd1);
        check("post_rst_aluSrcB", 32'(aluSrcB), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        for (int t = 0; t < 250; t++) begin
            int         pick;
            logic [5:0] o;
            pick = $urandom_range(0, 9);
            if (pick < 7) o = legal_ops[pick];
            else          o = 6'($urandom);
            run_instr(o, 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
